// File: rtl/arith_arbiter_pkg.sv
// Shared definitions for the two-requester arithmetic arbiter.
//   op_e      : operation codes carried on reqN_op
//   state_e   : arbiter FSM state encoding
//   W_*_DEF   : default operand / result widths
package arith_arbiter_pkg;

  localparam int unsigned W_OPND_DEF = 17;
  localparam int unsigned W_RES_DEF  = 20;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDiv = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDiv  = 2'b10,
    StResp = 2'b11
  } state_e;

endpackage

// File: rtl/arith_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
//   reqN_valid/ready/op/a/b : request channel of requester N (N = 0, 1)
//   rsp_valid/ready/id/...  : single shared response channel
//   busy                    : arbiter has an operation in flight
// master = requester/consumer side, slave = arbiter side.
interface arith_arbiter_if #(
  parameter int unsigned W_OPND = arith_arbiter_pkg::W_OPND_DEF,
  parameter int unsigned W_RES  = arith_arbiter_pkg::W_RES_DEF
);
  logic              req0_valid;
  logic              req0_ready;
  logic [1:0]        req0_op;
  logic [W_OPND-1:0] req0_a;
  logic [W_OPND-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [1:0]        req1_op;
  logic [W_OPND-1:0] req1_a;
  logic [W_OPND-1:0] req1_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [W_RES-1:0]  rsp_result;
  logic              rsp_neg;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_neg, rsp_err, busy
  );
endinterface

// File: rtl/arith_arbiter_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, W bits total.
//   clk, reset  : clock, synchronous active-high reset
//   i_start     : load operands; the first quotient bit is produced on this edge
//   i_dividend  : a
//   i_divisor   : b (must be non-zero)
//   o_done      : quotient valid (one-cycle pulse, W-1 cycles after the start edge)
//   o_quotient  : floor(a / b)
module seq_divider #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [W-1:0] w_rem_in;
  logic [W-1:0] w_quo_in;
  logic [W-1:0] w_div_in;
  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_rem_step;
  logic [W-1:0] w_quo_step;

  // One restoring step; on start it runs on the fresh operands so the
  // load edge already yields the first quotient bit.
  always_comb begin
    w_rem_in   = i_start ? '0 : r_rem;
    w_quo_in   = i_start ? i_dividend : r_quo;
    w_div_in   = i_start ? i_divisor : r_div;
    w_shift    = {w_rem_in, w_quo_in[W-1]};
    w_ge       = w_shift >= {1'b0, w_div_in};
    // Remainder after subtract is < divisor, so modulo-2^W subtraction is exact.
    w_rem_step = w_ge ? (w_shift[W-1:0] - w_div_in) : w_shift[W-1:0];
    w_quo_step = {w_quo_in[W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_step;
      r_quo  <= w_quo_step;
      r_div  <= i_divisor;
      r_cnt  <= CW'(W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done     = r_busy && (r_cnt == '0);
  assign o_quotient = r_quo;

endmodule

// File: rtl/arith_arbiter.sv
// Two-requester round-robin arbiter feeding one arithmetic unit
// (add / sub / mul inline, div via seq_divider). One operation in flight.
//   clk, reset : clock, synchronous active-high reset
//   bus        : arith_arbiter_if slave side (requests, response, busy)
module arith_arbiter #(
  parameter int unsigned W_OPND = arith_arbiter_pkg::W_OPND_DEF,
  parameter int unsigned W_RES  = arith_arbiter_pkg::W_RES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  arith_arbiter_if.slave  bus
);
  import arith_arbiter_pkg::*;

  localparam int unsigned W_PROD = 2 * W_OPND;

  state_e            r_state, w_state_d;
  logic              r_rr, w_rr_d;
  op_e               r_op, w_op_d;
  logic [W_OPND-1:0] r_a, w_a_d;
  logic [W_OPND-1:0] r_b, w_b_d;
  logic              r_id, w_id_d;
  logic [W_RES-1:0]  r_result, w_result_d;
  logic              r_neg, w_neg_d;
  logic              r_err, w_err_d;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_accept;
  op_e               w_sel_op;
  logic [W_OPND-1:0] w_sel_a;
  logic [W_OPND-1:0] w_sel_b;
  logic              w_div_start;
  logic              w_div_done;
  logic [W_OPND-1:0] w_div_quo;
  logic [W_PROD-1:0] w_prod;
  logic [W_RES-1:0]  w_exec_result;
  logic              w_exec_neg;
  logic              w_exec_err;

  // Grant: sole valid requester wins, ties go to the rr pointer.
  always_comb begin
    w_gnt_valid = (r_state == StIdle) && (bus.req0_valid || bus.req1_valid);
    w_gnt_id    = (bus.req0_valid && bus.req1_valid) ? r_rr : bus.req1_valid;
    w_accept    = w_gnt_valid;
    w_sel_op    = op_e'(w_gnt_id ? bus.req1_op : bus.req0_op);
    w_sel_a     = w_gnt_id ? bus.req1_a : bus.req0_a;
    w_sel_b     = w_gnt_id ? bus.req1_b : bus.req0_b;
    w_div_start = w_accept && (w_sel_op == OpDiv) && (w_sel_b != '0);
  end

  assign bus.req0_ready = w_gnt_valid && !w_gnt_id;
  assign bus.req1_ready = w_gnt_valid && w_gnt_id;

  seq_divider #(
    .W (W_OPND)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_sel_a),
    .i_divisor  (w_sel_b),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );

  // Single-cycle results from the latched operands.
  always_comb begin
    w_prod        = W_PROD'(r_a) * W_PROD'(r_b);
    w_exec_result = '0;
    w_exec_neg    = 1'b0;
    w_exec_err    = 1'b0;
    unique case (r_op)
      OpAdd: w_exec_result = W_RES'(r_a) + W_RES'(r_b);
      OpSub: begin
        w_exec_neg    = r_a < r_b;
        w_exec_result = w_exec_neg ? W_RES'(r_b - r_a) : W_RES'(r_a - r_b);
      end
      OpMul: begin
        w_exec_err    = (w_prod >> W_RES) != '0;
        w_exec_result = w_exec_err ? '1 : W_RES'(w_prod);
      end
      // Only reaches EXEC with b == 0.
      OpDiv: begin
        w_exec_err    = 1'b1;
        w_exec_result = '1;
      end
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_rr_d     = r_rr;
    w_op_d     = r_op;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_id_d     = r_id;
    w_result_d = r_result;
    w_neg_d    = r_neg;
    w_err_d    = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_op_d    = w_sel_op;
          w_a_d     = w_sel_a;
          w_b_d     = w_sel_b;
          w_id_d    = w_gnt_id;
          w_rr_d    = !w_gnt_id;
          w_state_d = w_div_start ? StDiv : StExec;
        end
      end
      StExec: begin
        w_result_d = w_exec_result;
        w_neg_d    = w_exec_neg;
        w_err_d    = w_exec_err;
        w_state_d  = StResp;
      end
      StDiv: begin
        if (w_div_done) begin
          w_result_d = W_RES'(w_div_quo);
          w_neg_d    = 1'b0;
          w_err_d    = 1'b0;
          w_state_d  = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_rr     <= 1'b0;
      r_op     <= OpAdd;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rr     <= w_rr_d;
      r_op     <= w_op_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_id     <= w_id_d;
      r_result <= w_result_d;
      r_neg    <= w_neg_d;
      r_err    <= w_err_d;
    end
  end

  assign bus.rsp_valid  = (r_state == StResp);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
  assign bus.rsp_neg    = r_neg;
  assign bus.rsp_err    = r_err;
  assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter: vector table for single operations plus
// hand sequences for round-robin alternation, response back-pressure and
// reset in the middle of a division.
module tb_arith_arbiter;
  localparam int unsigned WO = 17;
  localparam int unsigned WR = 20;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  arith_arbiter_if #(.W_OPND(WO), .W_RES(WR)) bus ();

  arith_arbiter #(
    .W_OPND (WO),
    .W_RES  (WR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    int unsigned a;
    int unsigned b;
    int unsigned res;
    logic        neg;
    logic        err;
    int unsigned lat;
  } vec_t;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input int unsigned a,
                       input int unsigned b);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = WO'(a); bus.req0_b = WO'(b);
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = WO'(a); bus.req1_b = WO'(b);
    end
  endtask

  // Waits for rsp_valid after an accept edge; returns edges counted (40 on timeout).
  task automatic wait_rsp(output int unsigned lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.rsp_valid) got = 1;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned lat;
    @(negedge clk);
    drive(v.id, v.op, v.a, v.b);
    #1;
    check($sformatf("v%0d ready", idx), v.id ? bus.req1_ready : bus.req0_ready, 1);
    check($sformatf("v%0d other_ready", idx), v.id ? bus.req0_ready : bus.req1_ready, 0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check($sformatf("v%0d busy", idx), bus.busy, 1);
    wait_rsp(lat);
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d id", idx), bus.rsp_id, v.id);
    check($sformatf("v%0d result", idx), bus.rsp_result, v.res);
    check($sformatf("v%0d neg", idx), bus.rsp_neg, v.neg);
    check($sformatf("v%0d err", idx), bus.rsp_err, v.err);
    handshake();
    check($sformatf("v%0d idle_after", idx), bus.busy, 0);
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned lat;
    int          n;
    int          cyc;
    int          both;
    int          stale;
    logic        gnt[4];

    total = 0;
    bad   = 0;
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 0;

    //         id    op     a       b      result   neg   err  lat
    vecs[0] = '{1'b0, 2'd0, 12345,  99,    12444,   1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 2'd1, 5,      30,    25,      1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 2'd3, 100000, 7,     14285,   1'b0, 1'b0, 17};
    vecs[3] = '{1'b0, 2'd3, 9,      0,     1048575, 1'b0, 1'b1, 1};
    vecs[4] = '{1'b1, 2'd2, 2000,   1000,  1048575, 1'b0, 1'b1, 1};
    vecs[5] = '{1'b0, 2'd2, 1024,   1023,  1047552, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b1, 2'd1, 30,     5,     25,      1'b0, 1'b0, 1};
    vecs[7] = '{1'b1, 2'd0, 131071, 131071, 262142, 1'b0, 1'b0, 1};
    vecs[8] = '{1'b0, 2'd3, 131071, 1,     131071,  1'b0, 1'b0, 17};

    // Reset state
    do_reset();
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst busy", bus.busy, 0);
    check("rst rsp_id", bus.rsp_id, 0);
    check("rst rsp_result", bus.rsp_result, 0);
    check("rst rsp_neg", bus.rsp_neg, 0);
    check("rst rsp_err", bus.rsp_err, 0);
    check("rst ready0", bus.req0_ready, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Both requesters valid from reset: grants alternate starting at 0.
    do_reset();
    @(negedge clk);
    drive(1'b0, 2'd0, 1, 1);
    drive(1'b1, 2'd0, 2, 2);
    bus.rsp_ready = 1'b1;
    n = 0; cyc = 0; both = 0;
    while (n < 4 && cyc < 100) begin
      if (cyc != 0) @(negedge clk);
      #1;
      cyc++;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.req0_ready || bus.req1_ready) begin
        gnt[n] = bus.req1_ready;
        n++;
      end
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp_ready  = 0;
    check("rr grant count", n, 4);
    check("rr both ready", both, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rr grant%0d", i), gnt[i], i % 2);

    // Back-pressure: response held while rsp_ready low, req1 waits.
    @(negedge clk);
    drive(1'b0, 2'd2, 1024, 1023);
    @(posedge clk);
    #1 bus.req0_valid = 0;
    drive(1'b1, 2'd0, 7, 8);
    wait_rsp(lat);
    check("hold latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d valid", i), bus.rsp_valid, 1);
      check($sformatf("hold%0d result", i), bus.rsp_result, 1047552);
      check($sformatf("hold%0d id", i), bus.rsp_id, 0);
      check($sformatf("hold%0d err", i), bus.rsp_err, 0);
      check($sformatf("hold%0d ready1", i), bus.req1_ready, 0);
    end
    handshake();
    check("post-hs ready1", bus.req1_ready, 1);
    @(posedge clk);
    #1 bus.req1_valid = 0;
    wait_rsp(lat);
    check("queued latency", lat, 1);
    check("queued id", bus.rsp_id, 1);
    check("queued result", bus.rsp_result, 15);
    handshake();

    // Reset in the middle of a division (rr is 1 after last req0 accept).
    @(negedge clk);
    drive(1'b0, 2'd3, 100000, 7);
    @(posedge clk);
    #1 bus.req0_valid = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort rsp_valid", bus.rsp_valid, 0);
    check("abort rsp_result", bus.rsp_result, 0);
    @(negedge clk);
    drive(1'b0, 2'd0, 1, 1);
    drive(1'b1, 2'd0, 1, 1);
    #1;
    check("abort rr ready0", bus.req0_ready, 1);
    check("abort rr ready1", bus.req1_ready, 0);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) stale++;
    end
    check("abort stale response", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 Parameter W_OPND, default 17, operand width in bits.
REQ-002 Parameter W_RES, default 20, result width in bits.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-007 reqN_op  input  2  (N=0,1) 00 add, 01 sub, 10 mul, 11 div.
REQ-008 reqN_a, reqN_b  input  W_OPND  (N=0,1) unsigned operands a (first), b (second).
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  index of requester that issued the operation.
REQ-012 rsp_result  output  W_RES  result magnitude.
REQ-013 rsp_neg  output  1  result is negative (sub only).
REQ-014 rsp_err  output  1  divide by zero or multiply overflow.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States IDLE, EXEC, DIV, RESP; exactly one operation in flight at any time.
REQ-017 reqN_ready is asserted only in IDLE, combinationally, for the single granted requester; never both at once.
REQ-018 Grant: one valid requester -> it; both valid -> requester indicated by round-robin pointer rr; neither -> no grant.
REQ-019 On accept (valid&&ready at edge k), operands/op/id latch and rr updates to point at the other requester.
REQ-020 IDLE -> EXEC on accept for add/sub/mul, or div with b=0; IDLE -> DIV for div with b!=0.
REQ-021 EXEC: computes and registers result; EXEC -> RESP at edge k+1; rsp_valid high from edge k+1.
REQ-022 DIV: restoring division, one quotient bit per cycle, W_OPND iterations; DIV -> RESP at edge k+W_OPND (17); rsp_valid high from that edge.
REQ-023 add: result = a+b, zero-extended, rsp_neg=0, rsp_err=0.
REQ-024 sub: a>=b -> result a-b, rsp_neg=0; a<b -> result b-a (magnitude), rsp_neg=1; rsp_err=0.
REQ-025 mul: full product; product > 2^W_RES-1 -> result all-ones, rsp_err=1; otherwise exact, rsp_err=0.
REQ-026 div: result = floor(a/b) zero-extended; b=0 -> result all-ones, rsp_err=1, no iterations.
REQ-027 RESP: rsp_id/rsp_result/rsp_neg/rsp_err held stable while rsp_valid && !rsp_ready.
REQ-028 RESP -> IDLE on rsp_valid&&rsp_ready; earliest next accept is the edge after that handshake.
REQ-029 Requests arriving during EXEC/DIV/RESP are not accepted; requesters hold valid and operands until ready.
REQ-030 rsp_valid is low in IDLE, EXEC and DIV.

Reset
REQ-031 reset forces state IDLE, rr=0 (requester 0 favoured), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_neg=0, rsp_err=0, busy=0, divider registers cleared.
REQ-032 reset during EXEC/DIV/RESP aborts the operation; no response is ever produced for it.
REQ-033 reset has priority over any simultaneous handshake.

Structure
REQ-034 Shared package holds op codes (ADD/SUB/MUL/DIV), W_OPND/W_RES defaults and the state encoding.
REQ-035 The iterative restoring divider is a separate sub-module seq_divider (start, operands, done, quotient).
REQ-036 add/sub/mul remain inline combinational logic registered in EXEC.

Verification
REQ-037 req0 add a=12345 b=99 alone -> req0_ready same cycle, rsp_valid one edge later, result 12444, id 0, neg 0, err 0.
REQ-038 req1 sub a=5 b=30 -> result 25, rsp_neg=1, rsp_err=0, id 1.
REQ-039 req0 div a=100000 b=7 -> busy 17 cycles, result 14285, err 0; div a=9 b=0 -> result 1048575, err 1, one-cycle latency.
REQ-040 mul a=2000 b=1000 -> result 1048575, err 1; mul a=1024 b=1023 -> 1047552, err 0.
REQ-041 Both valid continuously from reset -> grants alternate 0,1,0,1; rsp_ready low 5 cycles -> response held stable, no new accept.
REQ-042 reset asserted mid-DIV -> next cycle IDLE, rsp_valid 0, rr 0; no stale response after reset release.
